// File: rtl/game_pkg.sv
// Shared types and helpers for the symbol-counting game round sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE, PRELIM, GAME, ANSWER, POST, JUDGE, VICTORY, LOSE
  } gameStateT;

  localparam logic [3:0] PH_NONE   = 4'b0000;
  localparam logic [3:0] PH_PRE    = 4'b0001;
  localparam logic [3:0] PH_GAME   = 4'b0010;
  localparam logic [3:0] PH_ANSWER = 4'b0100;
  localparam logic [3:0] PH_POST   = 4'b1000;

  localparam int MAX_SECS = 255;
  localparam int SECS_W   = $clog2(MAX_SECS + 1);

  // Generator period for a level, floored at one step so it can never underflow.
  function automatic logic [31:0] symMaxFor(input logic [3:0] level,
                                            input logic [31:0] base,
                                            input logic [31:0] step);
    logic [35:0] prod;
    logic [35:0] base36;
    prod   = 36'(level) * 36'(step);
    base36 = 36'(base);
    if (prod >= base36 || (base36 - prod) < 36'(step)) return step;
    return base - prod[31:0];
  endfunction

endpackage

// File: rtl/game_round_sequencer_phase_timer.sv
// Loadable seconds down-counter shared by all timed phases of a round.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         tick,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic [W-1:0] secsLeft,
  output logic         done
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                          secsLeft <= '0;
    else if (clear)                     secsLeft <= '0;
    else if (load)                      secsLeft <= loadVal;
    else if (tick && secsLeft != '0)    secsLeft <= secsLeft - 1'b1;
  end

  assign done = tick && (secsLeft == W'(1));

endmodule

// File: rtl/game_round_sequencer.sv
// Round controller: prelim/game/answer/post phase sequencing, judging,
// level and lives tracking for the symbol-counting game.
//
// state   | meaning
// IDLE    | no round running
// PRELIM  | countdown before symbols appear
// GAME    | symbols generated, player counting
// ANSWER  | generator stopped, player finalises count
// POST    | difference captured, result pending
// JUDGE   | one-cycle pass/fail decision
// VICTORY | all levels passed, waiting for start
// LOSE    | out of lives, waiting for start
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int          NUM_LEVELS  = 8,
  parameter int          LIVES       = 3,
  parameter int          PRELIM_SECS = 3,
  parameter int          GAME_SECS   = 10,
  parameter int          ANSWER_SECS = 5,
  parameter int          POST_SECS   = 3,
  parameter int          TOLERANCE   = 0,
  parameter int          COUNT_W     = 8,
  parameter logic [31:0] SYM_BASE    = 32'd50_000_000,
  parameter logic [31:0] SYM_STEP    = 32'd5_000_000
) (
  input  logic               Clk100M,
  input  logic               RstN,
  input  logic               tick1Hz,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] userCount,
  input  logic [COUNT_W-1:0] magicCount,
  output logic [3:0]         phase,
  output logic [7:0]         secsLeft,
  output logic [3:0]         curLevel,
  output logic [3:0]         livesLeft,
  output logic [31:0]        symGenMax,
  output logic               startGen,
  output logic               stopGen,
  output logic               stopCount,
  output logic               roundPass,
  output logic               roundFail,
  output logic               victory,
  output logic               lose
);

  localparam logic [3:0]  LIVES_C    = 4'(LIVES);
  localparam logic [3:0]  LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [31:0] TOL_C      = 32'(TOLERANCE);

  gameStateT          state;
  logic [COUNT_W-1:0] diff;
  logic               timerDone;
  logic               timerLoad;
  logic               timerClear;
  logic [SECS_W-1:0]  timerLoadVal;
  logic               roundOk;
  logic               lastLevel;
  logic               lastLife;

  assign roundOk   = 32'(diff) <= TOL_C;
  assign lastLevel = curLevel == LAST_LEVEL;
  assign lastLife  = livesLeft <= 4'd1;

  // Timer reload decisions mirror the FSM transitions below.
  always_comb begin
    timerClear   = abort;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    if (!abort) begin
      case (state)
        IDLE, VICTORY, LOSE: begin
          timerLoad    = start;
          timerLoadVal = SECS_W'(PRELIM_SECS);
        end
        PRELIM: begin
          timerLoad    = timerDone;
          timerLoadVal = SECS_W'(GAME_SECS);
        end
        GAME: begin
          timerLoad    = timerDone;
          timerLoadVal = SECS_W'(ANSWER_SECS);
        end
        ANSWER: begin
          timerLoad    = timerDone;
          timerLoadVal = SECS_W'(POST_SECS);
        end
        POST:    timerClear = timerDone;
        JUDGE: begin
          timerLoad    = roundOk ? !lastLevel : !lastLife;
          timerLoadVal = SECS_W'(PRELIM_SECS);
        end
        default: timerClear = 1'b1;
      endcase
    end
  end

  phase_timer #(.W(SECS_W)) uTimer (
    .clk      (Clk100M),
    .rstN     (RstN),
    .tick     (tick1Hz),
    .clear    (timerClear),
    .load     (timerLoad),
    .loadVal  (timerLoadVal),
    .secsLeft (secsLeft),
    .done     (timerDone)
  );

  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) begin
      state     <= IDLE;
      phase     <= PH_NONE;
      curLevel  <= '0;
      livesLeft <= LIVES_C;
      diff      <= '0;
      startGen  <= 1'b0;
      stopGen   <= 1'b0;
      stopCount <= 1'b0;
      roundPass <= 1'b0;
      roundFail <= 1'b0;
      victory   <= 1'b0;
      lose      <= 1'b0;
    end else begin
      startGen  <= 1'b0;
      stopGen   <= 1'b0;
      roundPass <= 1'b0;
      roundFail <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        phase     <= PH_NONE;
        stopCount <= 1'b0;
        victory   <= 1'b0;
        lose      <= 1'b0;
      end else begin
        case (state)
          IDLE, VICTORY, LOSE: if (start) begin
            state     <= PRELIM;
            phase     <= PH_PRE;
            curLevel  <= '0;
            livesLeft <= LIVES_C;
            victory   <= 1'b0;
            lose      <= 1'b0;
          end
          PRELIM: if (timerDone) begin
            state    <= GAME;
            phase    <= PH_GAME;
            startGen <= 1'b1;
          end
          GAME: if (timerDone) begin
            state     <= ANSWER;
            phase     <= PH_ANSWER;
            stopGen   <= 1'b1;
            stopCount <= 1'b1;
          end
          ANSWER: if (timerDone) begin
            state <= POST;
            phase <= PH_POST;
            diff  <= (userCount >= magicCount) ? userCount - magicCount
                                               : magicCount - userCount;
          end
          POST: if (timerDone) begin
            state <= JUDGE;
            phase <= PH_NONE;
          end
          JUDGE: begin
            stopCount <= 1'b0;
            if (roundOk) begin
              roundPass <= 1'b1;
              if (lastLevel) begin
                state   <= VICTORY;
                phase   <= PH_NONE;
                victory <= 1'b1;
              end else begin
                state    <= PRELIM;
                phase    <= PH_PRE;
                curLevel <= curLevel + 4'd1;
              end
            end else begin
              roundFail <= 1'b1;
              livesLeft <= livesLeft - 4'd1;
              if (lastLife) begin
                state <= LOSE;
                phase <= PH_NONE;
                lose  <= 1'b1;
              end else begin
                state <= PRELIM;
                phase <= PH_PRE;
              end
            end
          end
          default: begin
            state <= IDLE;
            phase <= PH_NONE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) symGenMax <= SYM_BASE;
    else       symGenMax <= symMaxFor(curLevel, SYM_BASE, SYM_STEP);
  end

endmodule

// File: tb/tb_game_round_sequencer.sv
// Self-checking bench for game_round_sequencer: vector table, directed corner
// sequences, and randomized rounds against a round-level reference model.
module tb_game_round_sequencer;

  logic        Clk100M = 1'b0;
  logic        RstN = 1'b0;
  logic        tick1Hz = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [7:0]  userCount = '0;
  logic [7:0]  magicCount = '0;

  logic [3:0]  phase, phase2;
  logic [7:0]  secsLeft, secsLeft2;
  logic [3:0]  curLevel, curLevel2;
  logic [3:0]  livesLeft, livesLeft2;
  logic [31:0] symGenMax, symGenMax2;
  logic        startGen, stopGen, stopCount, roundPass, roundFail, victory, lose;
  logic        startGen2, stopGen2, stopCount2, roundPass2, roundFail2, victory2, lose2;

  int nChecks = 0;
  int nFail = 0;

  always #5 Clk100M = ~Clk100M;

  game_round_sequencer #(
    .NUM_LEVELS(2), .LIVES(2), .PRELIM_SECS(2), .GAME_SECS(3), .ANSWER_SECS(2),
    .POST_SECS(1), .TOLERANCE(1), .COUNT_W(8), .SYM_BASE(32'd1000), .SYM_STEP(32'd300)
  ) dut (
    .Clk100M(Clk100M), .RstN(RstN), .tick1Hz(tick1Hz), .start(start), .abort(abort),
    .userCount(userCount), .magicCount(magicCount), .phase(phase), .secsLeft(secsLeft),
    .curLevel(curLevel), .livesLeft(livesLeft), .symGenMax(symGenMax),
    .startGen(startGen), .stopGen(stopGen), .stopCount(stopCount),
    .roundPass(roundPass), .roundFail(roundFail), .victory(victory), .lose(lose)
  );

  // Second instance exercises the symGenMax floor with more levels.
  game_round_sequencer #(
    .NUM_LEVELS(4), .LIVES(1), .PRELIM_SECS(1), .GAME_SECS(1), .ANSWER_SECS(1),
    .POST_SECS(1), .TOLERANCE(255), .COUNT_W(8), .SYM_BASE(32'd100), .SYM_STEP(32'd40)
  ) dut2 (
    .Clk100M(Clk100M), .RstN(RstN), .tick1Hz(tick1Hz), .start(start2), .abort(abort2),
    .userCount(userCount), .magicCount(magicCount), .phase(phase2), .secsLeft(secsLeft2),
    .curLevel(curLevel2), .livesLeft(livesLeft2), .symGenMax(symGenMax2),
    .startGen(startGen2), .stopGen(stopGen2), .stopCount(stopCount2),
    .roundPass(roundPass2), .roundFail(roundFail2), .victory(victory2), .lose(lose2)
  );

  typedef struct packed {
    logic        t;
    logic        s;
    logic [3:0]  ph;
    logic [7:0]  secs;
    logic        sg;
    logic        sp;
    logic        sc;
    logic        rp;
    logic [3:0]  lvl;
    logic [31:0] sym;
  } vecT;

  vecT vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic a);
    tick1Hz = t;
    start   = s;
    abort   = a;
    @(posedge Clk100M);
    #1;
    tick1Hz = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
  endtask

  // From PRELIM with full time: 8 ticks, then the JUDGE cycle; leaves the result cycle visible.
  task automatic runRound(input logic [7:0] u, input logic [7:0] m);
    userCount  = u;
    magicCount = m;
    repeat (8) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Reference: phase layout as cumulative tick boundaries 2 | 5 | 7 | 8.
  task automatic chkTickPos(input int k);
    int cum[4];
    logic [3:0] ePh;
    int eSecs;
    cum = '{2, 5, 7, 8};
    ePh = 4'b0000;
    eSecs = 0;
    for (int i = 3; i >= 0; i--)
      if (k < cum[i]) begin
        ePh = 4'(1 << i);
        eSecs = cum[i] - k;
      end
    chk($sformatf("rand tick%0d phase", k), 32'(phase), 32'(ePh));
    chk($sformatf("rand tick%0d secsLeft", k), 32'(secsLeft), eSecs);
  endtask

  function automatic int expSym(input int level);
    int v;
    v = 1000 - 300 * level;
    return (v < 300) ? 300 : v;
  endfunction

  initial begin
    int mLevel, mLives, m, du, u;
    bit pass, ended;

    vecs[0]  = '{1'b0, 1'b1, 4'b0001, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1000};
    vecs[1]  = '{1'b1, 1'b0, 4'b0001, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1000};
    vecs[2]  = '{1'b1, 1'b0, 4'b0010, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1000};
    vecs[3]  = '{1'b0, 1'b0, 4'b0010, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1000};
    vecs[4]  = '{1'b1, 1'b0, 4'b0010, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1000};
    vecs[5]  = '{1'b1, 1'b0, 4'b0010, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd1000};
    vecs[6]  = '{1'b1, 1'b0, 4'b0100, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'd1000};
    vecs[7]  = '{1'b1, 1'b0, 4'b0100, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd1000};
    vecs[8]  = '{1'b1, 1'b0, 4'b1000, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd1000};
    vecs[9]  = '{1'b1, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd1000};
    vecs[10] = '{1'b0, 1'b0, 4'b0001, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'd1000};
    vecs[11] = '{1'b0, 1'b0, 4'b0001, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'd700};

    repeat (2) @(posedge Clk100M);
    #1 RstN = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    chk("reset phase", 32'(phase), 0);
    chk("reset secsLeft", 32'(secsLeft), 0);
    chk("reset curLevel", 32'(curLevel), 0);
    chk("reset livesLeft", 32'(livesLeft), 2);
    chk("reset symGenMax", symGenMax, 1000);
    chk("reset pulses", {startGen, stopGen, stopCount, roundPass, roundFail, victory, lose}, 0);

    repeat (3) step(1'b1, 1'b0, 1'b0);
    chk("idle ticks phase", 32'(phase), 0);
    chk("idle ticks secsLeft", 32'(secsLeft), 0);

    userCount  = 8'd5;
    magicCount = 8'd6;
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].t, vecs[i].s, 1'b0);
      chk($sformatf("vec%0d phase", i), 32'(phase), 32'(vecs[i].ph));
      chk($sformatf("vec%0d secsLeft", i), 32'(secsLeft), 32'(vecs[i].secs));
      chk($sformatf("vec%0d startGen", i), 32'(startGen), 32'(vecs[i].sg));
      chk($sformatf("vec%0d stopGen", i), 32'(stopGen), 32'(vecs[i].sp));
      chk($sformatf("vec%0d stopCount", i), 32'(stopCount), 32'(vecs[i].sc));
      chk($sformatf("vec%0d roundPass", i), 32'(roundPass), 32'(vecs[i].rp));
      chk($sformatf("vec%0d curLevel", i), 32'(curLevel), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d symGenMax", i), symGenMax, vecs[i].sym);
    end

    runRound(8'd5, 8'd6);
    chk("victory flag", 32'(victory), 1);
    chk("victory roundPass", 32'(roundPass), 1);
    chk("victory phase", 32'(phase), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("victory held", 32'(victory), 1);
    chk("victory pulse width", 32'(roundPass), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("restart phase", 32'(phase), 1);
    chk("restart curLevel", 32'(curLevel), 0);
    chk("restart victory", 32'(victory), 0);
    chk("restart secsLeft", 32'(secsLeft), 2);

    runRound(8'd5, 8'd9);
    chk("fail1 roundFail", 32'(roundFail), 1);
    chk("fail1 livesLeft", 32'(livesLeft), 1);
    chk("fail1 curLevel", 32'(curLevel), 0);
    chk("fail1 phase", 32'(phase), 1);
    runRound(8'd5, 8'd9);
    chk("fail2 lose", 32'(lose), 1);
    chk("fail2 livesLeft", 32'(livesLeft), 0);
    chk("fail2 phase", 32'(phase), 0);

    step(1'b0, 1'b0, 1'b1);
    chk("abort idle phase", 32'(phase), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("start+tick phase", 32'(phase), 1);
    chk("start+tick secsLeft", 32'(secsLeft), 2);

    repeat (5) step(1'b1, 1'b0, 1'b0);
    chk("answer phase", 32'(phase), 4);
    step(1'b0, 1'b1, 1'b0);
    chk("start in answer phase", 32'(phase), 4);
    chk("start in answer secsLeft", 32'(secsLeft), 2);

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pre-abort phase", 32'(phase), 2);
    step(1'b1, 1'b0, 1'b1);
    chk("abort+tick phase", 32'(phase), 0);
    chk("abort+tick secsLeft", 32'(secsLeft), 0);
    chk("abort+tick stopGen", 32'(stopGen), 0);
    chk("abort+tick stopCount", 32'(stopCount), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("after abort stopGen", 32'(stopGen), 0);

    step(1'b0, 1'b1, 1'b0);
    runRound(8'd255, 8'd0);
    chk("wrap 255-0 roundFail", 32'(roundFail), 1);
    chk("wrap 255-0 roundPass", 32'(roundPass), 0);
    runRound(8'd254, 8'd255);
    chk("diff 254/255 roundPass", 32'(roundPass), 1);
    runRound(8'd0, 8'd255);
    chk("wrap 0-255 lose", 32'(lose), 1);

    step(1'b0, 1'b1, 1'b0);
    runRound(8'd5, 8'd5);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("pre-reset phase", 32'(phase), 2);
    chk("pre-reset symGenMax", symGenMax, 700);
    #2 RstN = 1'b0;
    #1;
    chk("async reset phase", 32'(phase), 0);
    chk("async reset curLevel", 32'(curLevel), 0);
    chk("async reset livesLeft", 32'(livesLeft), 2);
    chk("async reset symGenMax", symGenMax, 1000);
    @(posedge Clk100M);
    #1 RstN = 1'b1;
    chk("reset held phase", 32'(phase), 0);

    start2 = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    start2 = 1'b0;
    chk("dut2 start phase", 32'(phase2), 1);
    for (int r = 0; r < 3; r++) begin
      repeat (4) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      if (r == 0) chk("dut2 level1 symGenMax", symGenMax2, 60);
    end
    chk("dut2 level3 curLevel", 32'(curLevel2), 3);
    chk("dut2 level3 saturated symGenMax", symGenMax2, 40);
    chk("main idle during dut2", 32'(phase), 0);

    step(1'b0, 1'b1, 1'b0);
    mLevel = 0;
    mLives = 2;
    chk("rand start phase", 32'(phase), 1);
    for (int r = 0; r < 30; r++) begin
      m  = int'($urandom_range(0, 20));
      du = int'($urandom_range(0, 4));
      u  = ($urandom_range(0, 1) == 1) ? m + du : ((m >= du) ? m - du : 0);
      userCount  = 8'(u);
      magicCount = 8'(m);
      for (int k = 1; k <= 8; k++) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chkTickPos(k);
      end
      step(1'b0, 1'b0, 1'b0);
      pass  = ((u > m) ? u - m : m - u) <= 1;
      ended = 1'b0;
      if (pass) begin
        if (mLevel == 1) ended = 1'b1;
        else mLevel++;
      end else begin
        mLives--;
        if (mLives == 0) ended = 1'b1;
      end
      chk($sformatf("rand r%0d roundPass", r), 32'(roundPass), 32'(pass));
      chk($sformatf("rand r%0d roundFail", r), 32'(roundFail), 32'(!pass));
      chk($sformatf("rand r%0d curLevel", r), 32'(curLevel), mLevel);
      chk($sformatf("rand r%0d livesLeft", r), 32'(livesLeft), mLives);
      chk($sformatf("rand r%0d victory", r), 32'(victory), 32'(ended && pass));
      chk($sformatf("rand r%0d lose", r), 32'(lose), 32'(ended && !pass));
      chk($sformatf("rand r%0d phase", r), 32'(phase), ended ? 0 : 1);
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("rand r%0d symGenMax", r), symGenMax, expSym(mLevel));
      if (ended) begin
        step(1'b0, 1'b1, 1'b0);
        mLevel = 0;
        mLives = 2;
        chk($sformatf("rand r%0d restart phase", r), 32'(phase), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/game_round_sequencer.md
# game_round_sequencer

Parametrised round controller for the symbol-counting game. It runs the prelim → game → answer → post phase sequence, judges each round and tracks level, lives and victory/lose. It replaces the separate start, period, judge and level-control blocks with one FSM. It sits between the 1 Hz tick source and the symbol generator, user counter and display control. Added over the fixed-function blocks: configurable level count and phase lengths, scoring tolerance, multiple lives, and abort.

## Interface
Parameters:
- NUM_LEVELS, 8: levels per game, ≥1
- LIVES, 3: misses allowed before lose, ≥1
- PRELIM_SECS / GAME_SECS / ANSWER_SECS / POST_SECS, 3/10/5/3: phase lengths in ticks, each ≥1
- TOLERANCE, 0: max |userCount − magicCount| that still passes
- COUNT_W, 8: width of the count inputs
- SYM_BASE, 32'd50_000_000: symGenMax at level 0
- SYM_STEP, 32'd5_000_000: symGenMax decrement per level

Ports:
- Clk100M  in  1  system clock; everything is synchronous to it
- RstN  in  1  asynchronous, active-low reset
- tick1Hz  in  1  one-cycle pulse per second, synchronous to Clk100M
- start  in  1  one-cycle start request
- abort  in  1  one-cycle abort request
- userCount  in  COUNT_W  player's count
- magicCount  in  COUNT_W  true special-symbol count
- phase  out  4  one-hot {post, answer, game, pre}; 0 outside a round
- secsLeft  out  8  ticks remaining in the current phase
- curLevel  out  4  current level, 0-based
- livesLeft  out  4  remaining lives
- symGenMax  out  32  generator period for the current level
- startGen  out  1  one-cycle pulse
- stopGen  out  1  one-cycle pulse
- stopCount  out  1  level output; freezes the user counter
- roundPass  out  1  one-cycle judge result pulse
- roundFail  out  1  one-cycle judge result pulse
- victory  out  1  level output
- lose  out  1  level output

## Operation
- States: IDLE, PRELIM, GAME, ANSWER, POST, JUDGE, VICTORY, LOSE.
- **Start:** IDLE, VICTORY or LOSE plus start → PRELIM. On this transition curLevel=0, livesLeft=LIVES and victory/lose clear. start in any other state is ignored.
- **Phase timing:** on entry to a timed phase, secsLeft loads that phase's length. Each tick decrements secsLeft. A tick while secsLeft==1 advances the state: PRELIM→GAME→ANSWER→POST→JUDGE.
- **Difference capture:** on entry to POST, diff = |userCount − magicCount| is registered using a COUNT_W-bit unsigned compare-and-subtract, so it never wraps.
- **Judge:** JUDGE lasts exactly one cycle.
  - Pass (diff ≤ TOLERANCE): if curLevel==NUM_LEVELS−1 → VICTORY; otherwise curLevel+1 → PRELIM.
  - Fail: livesLeft−1. If the result is 0 → LOSE; otherwise → PRELIM at the same level.
- **symGenMax:** SYM_BASE − curLevel·SYM_STEP, registered. It saturates at SYM_STEP (no underflow).
- **Abort:** abort in any state → IDLE; phase=0 and all pulses are suppressed. abort has priority over start and tick.
- **Phase outputs:** phase bits follow the state. secsLeft=0 in IDLE, JUDGE, VICTORY and LOSE.

## Timing
- **Reset values:** state IDLE, phase=0, secsLeft=0, curLevel=0, livesLeft=LIVES, symGenMax=SYM_BASE, all pulses 0, stopCount=0, victory=0, lose=0.
- All outputs are registered; the state advances on the same edge as the qualifying tick.
- startGen is high for the first cycle in GAME; stopGen for the first cycle in ANSWER.
- stopCount is high through ANSWER, POST and JUDGE. It drops on the edge that leaves JUDGE.
- roundPass/roundFail are high in the cycle after JUDGE, coincident with the new state.
- symGenMax updates one cycle after curLevel.
- **Simultaneous events:** start and tick in IDLE → PRELIM, and that tick is not counted. abort and tick → IDLE.
- A reset mid-round returns all outputs to their reset values immediately (asynchronously).

## Structure
- Package game_pkg: state enum, phase one-hot constants, and a clog2-based width for secsLeft.
- Sub-module phase_timer:
  - function: loadable down-counter with tick enable and a `done` output (secsLeft==1 && tick)
  - users: instantiated once and shared by all timed phases.
- The FSM, judge and level/lives registers live in the top module.

## Test plan
Common parameters: PRELIM=2, GAME=3, ANSWER=2, POST=1, NUM_LEVELS=2, LIVES=2, TOLERANCE=1.
- **Reset/idle:** RstN low mid-GAME → next cycle phase=0, livesLeft=2, symGenMax=SYM_BASE; ticks in IDLE → no change.
- **Full pass, level 0:** start, 8 ticks, userCount=5, magicCount=6 → phases 0001/0010/0100/1000 with secsLeft 2,1/3,2,1/2,1/1; startGen and stopGen each pulse once; roundPass; curLevel=1; symGenMax=SYM_BASE−SYM_STEP.
- **Fail then lose:** magicCount=9, userCount=5 on two rounds → first roundFail gives livesLeft=1 and curLevel stays 0; second → lose=1, livesLeft=0.
- **Victory:** pass levels 0 and 1 → victory=1 after the second JUDGE; start → PRELIM, curLevel=0, victory=0.
- **Priority:** abort together with tick in GAME → IDLE with no stopGen; start during ANSWER → ignored; start together with tick in IDLE → secsLeft=2.
- **Wrap/saturation:** userCount=255, magicCount=0, COUNT_W=8 → diff=255 and roundFail. SYM_STEP·level > SYM_BASE → symGenMax=SYM_STEP.
